// File: rtl/prince_cfb_seq.sv
// Sequencer feeding one 16-bit word at a time through an external prince_cfb engine.
// Define PRINCE_CFB_SEQ_TIMEOUT_EN to build the engine-completion timeout and sticky timeout_err.
module prince_cfb_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_encrypt,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        eng_block_start,
  output logic        eng_encrypt,
  output logic [15:0] eng_plain_text,
  input  logic        eng_block_done,
  input  logic        eng_block_busy_n,
  input  logic [15:0] eng_cipher_text,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    START    = 3'd2,
    BUSY     = 3'd3,
    OUT      = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        s_ready_q, s_ready_d;
  logic        m_valid_q, m_valid_d;
  logic        start_q, start_d;
  logic        enc_q, enc_d;
  logic [15:0] pt_q, pt_d;
  logic [15:0] md_q, md_d;
  logic        tmo_q, tmo_d;

`ifdef PRINCE_CFB_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    pt_d    = pt_q;
    enc_d   = enc_q;
    md_d    = md_q;
    tmo_d   = tmo_q;
`ifdef PRINCE_CFB_SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (s_valid && s_ready_q) begin
          pt_d    = s_data;
          enc_d   = s_encrypt;
          state_d = eng_block_busy_n ? START : WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (eng_block_busy_n) state_d = START;
      end
      START: begin
        state_d = BUSY;
`ifdef PRINCE_CFB_SEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      BUSY: begin
        if (eng_block_done) begin
          md_d    = eng_cipher_text;
          state_d = OUT;
        end
`ifdef PRINCE_CFB_SEQ_TIMEOUT_EN
        // The word is dropped on timeout; the flag stays set until reset.
        else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      OUT: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake/strobe outputs are registered from the next state.
    s_ready_d = (state_d == IDLE);
    m_valid_d = (state_d == OUT);
    start_d   = (state_d == START);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      start_q   <= 1'b0;
      enc_q     <= 1'b0;
      pt_q      <= 16'h0000;
      md_q      <= 16'h0000;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      start_q   <= start_d;
      enc_q     <= enc_d;
      pt_q      <= pt_d;
      md_q      <= md_d;
      tmo_q     <= tmo_d;
    end
  end

`ifdef PRINCE_CFB_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 16'h0000;
    else     cnt_q <= cnt_d;
  end
`endif

  assign s_ready         = s_ready_q;
  assign m_valid         = m_valid_q;
  assign m_data          = md_q;
  assign eng_block_start = start_q;
  assign eng_encrypt     = enc_q;
  assign eng_plain_text  = pt_q;
  assign timeout_err     = tmo_q;

endmodule
